// File: rtl/tile_map_wr_if.sv
// Host-side write port of the tile map: shadow-bank tile writes with valid/ready, plus a whole-map clear pulse.
interface tile_map_wr_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [4:0] wr_row;
   logic [5:0] wr_col;
   logic       wr_data;
   logic       clr_req;

   modport master (
      output wr_valid, wr_row, wr_col, wr_data, clr_req,
      input  wr_ready
   );

   modport slave (
      input  wr_valid, wr_row, wr_col, wr_data, clr_req,
      output wr_ready
   );
endinterface

// File: rtl/tile_map.sv
// Double-buffered 40x30 tile map: host writes shadow, VS fall copies shadow->active row per cycle, pixel path reads active (1-cycle latency).
// Optional TILE_MAP_BORDER_EN forces the outer ring of in-range tiles solid.
module tile_map #(
   parameter int TILE_SHIFT = 4,
   parameter int MAP_W      = 40,
   parameter int MAP_H      = 30
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic [9:0]   DrawX,
   input  logic [9:0]   DrawY,
   input  logic         VS,
   tile_map_wr_if.slave wr,
   output logic         tile_on,
   output logic [9:0]   DrawX_q,
   output logic [9:0]   DrawY_q,
   output logic         busy,
   output logic         swap_done
);

   typedef enum logic {IDLE, COPY} state_t;

   localparam logic [9:0] X_LIM    = 10'(MAP_W << TILE_SHIFT);
   localparam logic [9:0] Y_LIM    = 10'(MAP_H << TILE_SHIFT);
   localparam logic [4:0] ROW_LIM  = 5'(MAP_H);
   localparam logic [5:0] COL_LIM  = 6'(MAP_W);
   localparam logic [4:0] LAST_ROW = 5'(MAP_H - 1);

   state_t           state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic             vs_q, vs_d;
   logic             swap_done_q, swap_done_d;
   logic             tile_on_q, tile_on_d;
   logic [9:0]       dx_q, dx_d;
   logic [9:0]       dy_q, dy_d;
   logic [MAP_W-1:0] shadow_q [MAP_H];
   logic [MAP_W-1:0] shadow_d [MAP_H];
   logic [MAP_W-1:0] active_q [MAP_H];
   logic [MAP_W-1:0] active_d [MAP_H];

   logic             vs_fall;
   logic             wr_acc;
   logic             in_range;
   logic [5:0]       pix_col;
   logic [4:0]       pix_row;

   // Ready is held low during reset so nothing can be accepted before the banks are cleared.
   assign wr.wr_ready = Reset_n && (state_q == IDLE) && !wr.clr_req;
   assign wr_acc      = wr.wr_valid && wr.wr_ready;
   assign vs_fall     = vs_q && !VS;

   assign in_range = (DrawX < X_LIM) && (DrawY < Y_LIM);
   assign pix_col  = 6'(DrawX >> TILE_SHIFT);
   assign pix_row  = 5'(DrawY >> TILE_SHIFT);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      vs_d        = VS;
      swap_done_d = 1'b0;
      shadow_d    = shadow_q;
      active_d    = active_q;
      dx_d        = DrawX;
      dy_d        = DrawY;
      tile_on_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (wr.clr_req) begin
               for (int r = 0; r < MAP_H; r++) shadow_d[r] = '0;
            end else if (wr_acc && (wr.wr_row < ROW_LIM) && (wr.wr_col < COL_LIM)) begin
               shadow_d[wr.wr_row][wr.wr_col] = wr.wr_data;
            end
            if (vs_fall) begin
               state_d = COPY;
               cnt_d   = '0;
            end
         end
         COPY: begin
            active_d[cnt_q] = shadow_q[cnt_q];
            if (cnt_q == LAST_ROW) begin
               state_d     = IDLE;
               cnt_d       = '0;
               swap_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (in_range) begin
         tile_on_d = active_q[pix_row][pix_col];
`ifdef TILE_MAP_BORDER_EN
         if ((pix_row == 5'd0) || (pix_row == LAST_ROW) ||
             (pix_col == 6'd0) || (pix_col == 6'(MAP_W - 1))) begin
            tile_on_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         vs_q        <= 1'b1;
         swap_done_q <= 1'b0;
         tile_on_q   <= 1'b0;
         dx_q        <= '0;
         dy_q        <= '0;
         for (int r = 0; r < MAP_H; r++) begin
            shadow_q[r] <= '0;
            active_q[r] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         vs_q        <= vs_d;
         swap_done_q <= swap_done_d;
         tile_on_q   <= tile_on_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         shadow_q    <= shadow_d;
         active_q    <= active_d;
      end
   end

   assign tile_on   = tile_on_q;
   assign DrawX_q   = dx_q;
   assign DrawY_q   = dy_q;
   assign busy      = (state_q == COPY);
   assign swap_done = swap_done_q;

endmodule

// File: tb/tb_tile_map.sv
// Directed bench for tile_map: reset, blank frame, write/swap, backpressure during copy, clear, range limits, reset mid-copy.
module tb_tile_map;

   logic       Clk;
   logic       Reset_n;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       VS;
   logic       tile_on;
   logic [9:0] DrawX_q;
   logic [9:0] DrawY_q;
   logic       busy;
   logic       swap_done;

   int vectors = 0;
   int errors  = 0;

`ifdef TILE_MAP_BORDER_EN
   localparam bit BORDER = 1'b1;
`else
   localparam bit BORDER = 1'b0;
`endif

   tile_map_wr_if wr_if ();

   tile_map dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .DrawX     (DrawX),
      .DrawY     (DrawY),
      .VS        (VS),
      .wr        (wr_if.slave),
      .tile_on   (tile_on),
      .DrawX_q   (DrawX_q),
      .DrawY_q   (DrawY_q),
      .busy      (busy),
      .swap_done (swap_done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic bord(input int x, input int y);
      return BORDER && (x < 640) && (y < 480) && ((x < 16) || (x >= 624) || (y < 16) || (y >= 464));
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic pix(input int x, input int y, output logic t);
      DrawX = 10'(x);
      DrawY = 10'(y);
      tick();
      t = tile_on;
   endtask

   task automatic do_write(input int r, input int c, input logic d, output logic rdy);
      wr_if.wr_row   = 5'(r);
      wr_if.wr_col   = 6'(c);
      wr_if.wr_data  = d;
      wr_if.wr_valid = 1'b1;
      #1;
      rdy = wr_if.wr_ready;
      tick();
      wr_if.wr_valid = 1'b0;
   endtask

   // VS low for one cycle, then count busy cycles (bounded); sd is swap_done right after busy drops.
   task automatic do_swap(output int n, output logic sd);
      VS = 1'b0;
      tick();
      VS = 1'b1;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         tick();
      end
      sd = swap_done;
   endtask

   task automatic test_reset();
      logic t;
      Reset_n = 1'b0;
      DrawX = 10'd100;
      DrawY = 10'd200;
      tick();
      tick();
      vectors++; if (tile_on !== 1'b0) begin errors++; $display("FAIL reset_tile_on: got %b want 0", tile_on); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (swap_done !== 1'b0) begin errors++; $display("FAIL reset_swap_done: got %b want 0", swap_done); end
      vectors++; if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b want 0", wr_if.wr_ready); end
      vectors++; if (DrawX_q !== 10'd0 || DrawY_q !== 10'd0) begin errors++; $display("FAIL reset_draw_q: got %0d,%0d want 0,0", DrawX_q, DrawY_q); end
      Reset_n = 1'b1;
      #1;
      vectors++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL idle_wr_ready: got %b want 1", wr_if.wr_ready); end
      pix(0, 0, t);
      vectors++; if (t !== bord(0, 0)) begin errors++; $display("FAIL pix_0_0: got %b want %b", t, bord(0, 0)); end
   endtask

   task automatic test_blank_frame();
      logic t;
      for (int y = 0; y < 480; y += 8) begin
         for (int x = 0; x < 640; x += 8) begin
            pix(x, y, t);
            vectors++;
            if (t !== bord(x, y)) begin errors++; $display("FAIL blank_%0d_%0d: got %b want %b", x, y, t, bord(x, y)); end
         end
      end
      pix(123, 456, t);
      vectors++; if (DrawX_q !== 10'd123 || DrawY_q !== 10'd456) begin errors++; $display("FAIL draw_q_align: got %0d,%0d want 123,456", DrawX_q, DrawY_q); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL blank_busy: got %b want 0", busy); end
      vectors++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL blank_wr_ready: got %b want 1", wr_if.wr_ready); end
   endtask

   task automatic test_write_no_swap();
      logic t, rdy;
      do_write(2, 5, 1'b1, rdy);
      vectors++; if (rdy !== 1'b1) begin errors++; $display("FAIL w25_ready: got %b want 1", rdy); end
      repeat (5) tick();
      pix(80, 32, t);
      vectors++; if (t !== 1'b0) begin errors++; $display("FAIL noswap_80_32: got %b want 0", t); end
   endtask

   task automatic test_write_swap();
      logic t, sd;
      int n;
      do_swap(n, sd);
      vectors++; if (n !== 30) begin errors++; $display("FAIL swap_busy_cycles: got %0d want 30", n); end
      vectors++; if (sd !== 1'b1) begin errors++; $display("FAIL swap_done_pulse: got %b want 1", sd); end
      tick();
      vectors++; if (swap_done !== 1'b0) begin errors++; $display("FAIL swap_done_width: got %b want 0", swap_done); end
      pix(80, 32, t);  vectors++; if (t !== 1'b1) begin errors++; $display("FAIL swap_80_32: got %b want 1", t); end
      pix(95, 47, t);  vectors++; if (t !== 1'b1) begin errors++; $display("FAIL swap_95_47: got %b want 1", t); end
      pix(88, 40, t);  vectors++; if (t !== 1'b1) begin errors++; $display("FAIL swap_88_40: got %b want 1", t); end
      pix(96, 32, t);  vectors++; if (t !== 1'b0) begin errors++; $display("FAIL swap_96_32: got %b want 0", t); end
      pix(79, 32, t);  vectors++; if (t !== 1'b0) begin errors++; $display("FAIL swap_79_32: got %b want 0", t); end
      pix(80, 48, t);  vectors++; if (t !== 1'b0) begin errors++; $display("FAIL swap_80_48: got %b want 0", t); end
      pix(80, 31, t);  vectors++; if (t !== 1'b0) begin errors++; $display("FAIL swap_80_31: got %b want 0", t); end
   endtask

   task automatic test_back_to_back();
      logic t, sd;
      int n, lowcnt;
      VS = 1'b0;
      tick();
      VS = 1'b1;
      wr_if.wr_row = 5'd3; wr_if.wr_col = 6'd6; wr_if.wr_data = 1'b1; wr_if.wr_valid = 1'b1;
      n = 0; lowcnt = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         if (wr_if.wr_ready === 1'b0) lowcnt++;
         tick();
      end
      vectors++; if (n !== 30) begin errors++; $display("FAIL held_busy_cycles: got %0d want 30", n); end
      vectors++; if (lowcnt !== 30) begin errors++; $display("FAIL held_ready_low: got %0d want 30", lowcnt); end
      vectors++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL held_ready_idle: got %b want 1", wr_if.wr_ready); end
      tick();
      wr_if.wr_valid = 1'b0;
      pix(96, 48, t);  vectors++; if (t !== 1'b0) begin errors++; $display("FAIL held_not_shown: got %b want 0", t); end
      pix(80, 32, t);  vectors++; if (t !== 1'b1) begin errors++; $display("FAIL held_keep_80_32: got %b want 1", t); end
      // Write accepted on the same edge as the VS fall must make it into this copy.
      wr_if.wr_row = 5'd4; wr_if.wr_col = 6'd7; wr_if.wr_data = 1'b1; wr_if.wr_valid = 1'b1;
      VS = 1'b0;
      tick();
      wr_if.wr_valid = 1'b0;
      VS = 1'b1;
      n = 0;
      while (busy === 1'b1 && n < 100) begin n++; tick(); end
      sd = swap_done;
      vectors++; if (n !== 30) begin errors++; $display("FAIL same_busy_cycles: got %0d want 30", n); end
      vectors++; if (sd !== 1'b1) begin errors++; $display("FAIL same_swap_done: got %b want 1", sd); end
      pix(112, 64, t); vectors++; if (t !== 1'b1) begin errors++; $display("FAIL same_112_64: got %b want 1", t); end
      pix(96, 48, t);  vectors++; if (t !== 1'b1) begin errors++; $display("FAIL held_96_48: got %b want 1", t); end
   endtask

   task automatic test_clear();
      logic t, sd;
      int n;
      wr_if.clr_req = 1'b1;
      wr_if.wr_row = 5'd10; wr_if.wr_col = 6'd10; wr_if.wr_data = 1'b1; wr_if.wr_valid = 1'b1;
      #1;
      vectors++; if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL clr_ready: got %b want 0", wr_if.wr_ready); end
      tick();
      wr_if.clr_req = 1'b0;
      wr_if.wr_valid = 1'b0;
      #1;
      vectors++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL clr_ready_after: got %b want 1", wr_if.wr_ready); end
      pix(80, 32, t);  vectors++; if (t !== 1'b1) begin errors++; $display("FAIL clr_active_kept: got %b want 1", t); end
      do_swap(n, sd);
      vectors++; if (n !== 30) begin errors++; $display("FAIL clr_busy_cycles: got %0d want 30", n); end
      pix(80, 32, t);   vectors++; if (t !== 1'b0) begin errors++; $display("FAIL clr_80_32: got %b want 0", t); end
      pix(96, 48, t);   vectors++; if (t !== 1'b0) begin errors++; $display("FAIL clr_96_48: got %b want 0", t); end
      pix(112, 64, t);  vectors++; if (t !== 1'b0) begin errors++; $display("FAIL clr_112_64: got %b want 0", t); end
      pix(160, 160, t); vectors++; if (t !== 1'b0) begin errors++; $display("FAIL clr_dropped_write: got %b want 0", t); end
   endtask

   task automatic test_out_of_range();
      logic t, rdy, sd, exp;
      int n;
      do_write(31, 10, 1'b1, rdy);
      vectors++; if (rdy !== 1'b1) begin errors++; $display("FAIL oor_row_ready: got %b want 1", rdy); end
      do_write(5, 40, 1'b1, rdy);
      vectors++; if (rdy !== 1'b1) begin errors++; $display("FAIL oor_col_ready: got %b want 1", rdy); end
      do_write(29, 39, 1'b1, rdy);
      do_swap(n, sd);
      vectors++; if (n !== 30) begin errors++; $display("FAIL oor_busy_cycles: got %0d want 30", n); end
      pix(639, 479, t); vectors++; if (t !== 1'b1) begin errors++; $display("FAIL oor_639_479: got %b want 1", t); end
      pix(624, 464, t); vectors++; if (t !== 1'b1) begin errors++; $display("FAIL oor_624_464: got %b want 1", t); end
      pix(640, 479, t); vectors++; if (t !== 1'b0) begin errors++; $display("FAIL oor_640_479: got %b want 0", t); end
      pix(639, 480, t); vectors++; if (t !== 1'b0) begin errors++; $display("FAIL oor_639_480: got %b want 0", t); end
      pix(640, 0, t);   vectors++; if (t !== 1'b0) begin errors++; $display("FAIL oor_640_0: got %b want 0", t); end
      pix(0, 480, t);   vectors++; if (t !== 1'b0) begin errors++; $display("FAIL oor_0_480: got %b want 0", t); end
      for (int r = 0; r < 30; r++) begin
         for (int c = 0; c < 40; c++) begin
            pix(c * 16 + 8, r * 16 + 8, t);
            exp = ((r == 29) && (c == 39)) || bord(c * 16 + 8, r * 16 + 8);
            vectors++;
            if (t !== exp) begin errors++; $display("FAIL oor_map_r%0d_c%0d: got %b want %b", r, c, t, exp); end
         end
      end
   endtask

   task automatic test_reset_mid_copy();
      logic t, rdy, sd;
      int n;
      do_write(7, 7, 1'b1, rdy);
      VS = 1'b0;
      tick();
      VS = 1'b1;
      repeat (10) tick();
      vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
      Reset_n = 1'b0;
      #1;
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
      tick();
      Reset_n = 1'b1;
      pix(639, 479, t); vectors++; if (t !== bord(639, 479)) begin errors++; $display("FAIL mid_active_cleared: got %b want %b", t, bord(639, 479)); end
      do_swap(n, sd);
      vectors++; if (n !== 30) begin errors++; $display("FAIL mid_busy_cycles: got %0d want 30", n); end
      pix(112, 112, t); vectors++; if (t !== 1'b0) begin errors++; $display("FAIL mid_shadow_cleared: got %b want 0", t); end
   endtask

   initial begin
      Reset_n = 1'b0;
      DrawX = '0;
      DrawY = '0;
      VS = 1'b1;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_row = '0;
      wr_if.wr_col = '0;
      wr_if.wr_data = 1'b0;
      wr_if.clr_req = 1'b0;
      test_reset();
      test_blank_frame();
      test_write_no_swap();
      test_write_swap();
      test_back_to_back();
      test_clear();
      test_out_of_range();
      test_reset_mid_copy();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
